seg7_arbiter: RTL and testbench

- Shares the six on-board seven-segment digits (hex0..hex5, driven through the JTAG pin IP) between up to NUM_REQ independent requesters.
- Arbitration is round-robin with a guaranteed minimum hold time per grant.
- A one-cycle blank gap separates owners, so digits from two requesters never mix.
- Sits between user design blocks and the pin IP's seg7 inputs in the top level.

---
 rtl/seg7_pkg.sv | 16 +
 rtl/rr_pick.sv | 39 +++
 rtl/seg7_arbiter.sv | 144 ++++++++++++++
 tb/tb_seg7_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Segments are active-low, so an all-ones digit is dark.
package seg7_pkg;

  localparam int unsigned DIGIT_BITS = 8;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned BANK_BITS  = DIGIT_BITS * NUM_DIGITS;

  typedef logic [DIGIT_BITS-1:0] seg_t;
  typedef seg_t [NUM_DIGITS-1:0] seg_bank_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {IDLE, OWN, GAP} arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after start,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] start,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       valid
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [31:0]          pos;

  // Rotate so bit 0 of rot is the requester at 'start'.
  assign dbl = {req, req};
  assign rot = NUM_REQ'(dbl >> start);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    // Scan downwards so the smallest offset from start wins.
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos   = 32'(start) + 32'(i);
        valid = 1'b1;
      end
    end
    if (pos >= NUM_REQ) begin
      pos = pos - NUM_REQ;
    end
    idx = IW'(pos);
  end

endmodule

// File: rtl/seg7_arbiter.sv
// Round-robin arbiter sharing the six seven-segment digits between requesters,
// with a minimum hold per grant and a one-cycle blank gap between owners.
module seg7_arbiter
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic                           max10_clk1_50,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*BANK_BITS-1:0]   req_hex,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [$clog2(NUM_REQ)-1:0]     owner,
  output logic                           busy,
  output seg_t                           hex0,
  output seg_t                           hex1,
  output seg_t                           hex2,
  output seg_t                           hex3,
  output seg_t                           hex4,
  output seg_t                           hex5
);

  localparam int unsigned OW = $clog2(NUM_REQ);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  arb_state_t          state;
  arb_state_t          state_nxt;
  logic [OW-1:0]       owner_nxt;
  logic [OW-1:0]       rr_ptr;
  logic [OW-1:0]       rr_ptr_nxt;
  logic [HW-1:0]       hold_cnt;
  logic [HW-1:0]       hold_nxt;
  logic [OW-1:0]       pick_idx;
  logic                pick_valid;
  logic [NUM_REQ-1:0]  owner_mask;
  logic                others_req;
  logic [NUM_REQ-1:0]  gnt_nxt;
  seg_bank_t           bank_sel;
  seg_t                hex_nxt [NUM_DIGITS];
  seg_t                hex_q   [NUM_DIGITS];

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req   (req),
    .start (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Any requester other than the current owner wants the display.
  always_comb begin
    owner_mask        = '0;
    owner_mask[owner] = 1'b1;
    others_req        = |(req & ~owner_mask);
  end

  // Next-state, owner, pointer and hold counter.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    hold_nxt   = (hold_cnt == '0) ? '0 : hold_cnt - HW'(1);
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = OWN;
          owner_nxt = pick_idx;
          hold_nxt  = HOLD_LOAD;
        end
      end
      OWN: begin
        // A drop coinciding with hold expiry lands in GAP either way.
        if (!req[owner] || ((hold_cnt == '0) && others_req)) begin
          state_nxt  = GAP;
          rr_ptr_nxt = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);
        end
      end
      GAP: begin
        if (pick_valid) begin
          state_nxt = OWN;
          owner_nxt = pick_idx;
          hold_nxt  = HOLD_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Grant vector and digit drive for the upcoming cycle.
  always_comb begin
    gnt_nxt  = '0;
    bank_sel = '0;
    for (int r = 0; r < int'(NUM_REQ); r++) begin
      if (owner_nxt == OW'(r)) begin
        bank_sel = req_hex[r*BANK_BITS +: BANK_BITS];
      end
    end
    if (state_nxt == OWN) begin
      gnt_nxt[owner_nxt] = 1'b1;
    end
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      hex_nxt[d] = (state_nxt == OWN) ? bank_sel[d] : SEG_BLANK;
    end
  end

  always_ff @(posedge max10_clk1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      busy     <= 1'b0;
      for (int d = 0; d < int'(NUM_DIGITS); d++) begin
        hex_q[d] <= SEG_BLANK;
      end
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      busy     <= (state_nxt == OWN);
      for (int d = 0; d < int'(NUM_DIGITS); d++) begin
        hex_q[d] <= hex_nxt[d];
      end
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

endmodule

// File: tb/tb_seg7_arbiter.sv
// Directed bench for seg7_arbiter with NUM_REQ=4, HOLD_CYCLES=4.
// Requester r digit d is preloaded as 8'h{r}{d} so each owner's digits are distinct.
module tb_seg7_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned HOLD = 4;
  localparam logic [47:0] BLANK_ALL = 48'hFFFF_FFFF_FFFF;

  logic         clk;
  logic         reset_n;
  logic [3:0]   req;
  logic [191:0] req_hex;
  logic [3:0]   gnt;
  logic [1:0]   owner;
  logic         busy;
  logic [7:0]   hex0, hex1, hex2, hex3, hex4, hex5;
  logic [47:0]  shown;

  int total  = 0;
  int passed = 0;
  int bad;

  seg7_arbiter #(
    .NUM_REQ     (NREQ),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .max10_clk1_50 (clk),
    .reset_n       (reset_n),
    .req           (req),
    .req_hex       (req_hex),
    .gnt           (gnt),
    .owner         (owner),
    .busy          (busy),
    .hex0          (hex0),
    .hex1          (hex1),
    .hex2          (hex2),
    .hex3          (hex3),
    .hex4          (hex4),
    .hex5          (hex5)
  );

  assign shown = {hex5, hex4, hex3, hex2, hex1, hex0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    req     = '0;
    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < 6; d++) begin
        req_hex[r*48 + d*8 +: 8] = 8'((r << 4) | d);
      end
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_gnt",   64'(gnt),   64'h0);
    check("rst_busy",  64'(busy),  64'h0);
    check("rst_owner", 64'(owner), 64'h0);
    check("rst_hex",   64'(shown), 64'(BLANK_ALL));
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_gnt", 64'(gnt), 64'h0);

    // Single request and live data follow
    req = 4'b0001;
    req_hex[7:0] = 8'hC0;
    @(negedge clk);
    check("single_gnt",   64'(gnt),   64'h1);
    check("single_busy",  64'(busy),  64'h1);
    check("single_owner", 64'(owner), 64'h0);
    check("single_hex0",  64'(hex0),  64'hC0);
    check("single_hex1",  64'(hex1),  64'h01);
    req_hex[7:0] = 8'hF9;
    @(negedge clk);
    check("follow_hex0", 64'(hex0), 64'hF9);
    check("follow_gnt",  64'(gnt),  64'h1);

    // Voluntary release: one GAP cycle, then IDLE
    req = 4'b0000;
    @(negedge clk);
    check("rel_gap_gnt",  64'(gnt),   64'h0);
    check("rel_gap_busy", 64'(busy),  64'h0);
    check("rel_gap_hex",  64'(shown), 64'(BLANK_ALL));
    @(negedge clk);
    check("rel_idle_gnt",  64'(gnt),   64'h0);
    check("rel_idle_busy", 64'(busy),  64'h0);
    check("rel_idle_hex",  64'(shown), 64'(BLANK_ALL));

    // Lone owner keeps the display indefinitely
    req = 4'b0100;
    @(negedge clk);
    check("lone_gnt",   64'(gnt),   64'h4);
    check("lone_owner", 64'(owner), 64'h2);
    check("lone_hex",   64'(shown), 64'h25_24_23_22_21_20);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (gnt !== 4'b0100 || busy !== 1'b1) bad++;
    end
    check("lone_hold_bad_cycles", 64'(bad), 64'h0);
    req = 4'b0101;
    @(negedge clk);
    check("lone_preempt_gap_gnt", 64'(gnt),   64'h0);
    check("lone_preempt_gap_hex", 64'(shown), 64'(BLANK_ALL));
    @(negedge clk);
    check("lone_next_gnt",   64'(gnt),   64'h1);
    check("lone_next_owner", 64'(owner), 64'h0);
    check("lone_next_hex0",  64'(hex0),  64'hF9);

    // Owner 2 granted, then asynchronous reset mid-grant
    req = 4'b0100;
    @(negedge clk);
    check("to2_gap_gnt", 64'(gnt), 64'h0);
    @(negedge clk);
    check("to2_gnt",   64'(gnt),   64'h4);
    check("to2_owner", 64'(owner), 64'h2);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_gnt",   64'(gnt),   64'h0);
    check("async_rst_busy",  64'(busy),  64'h0);
    check("async_rst_owner", 64'(owner), 64'h0);
    check("async_rst_hex",   64'(shown), 64'(BLANK_ALL));
    @(negedge clk);
    req     = 4'b0000;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_gnt",  64'(gnt),  64'h0);
    check("post_rst_busy", 64'(busy), 64'h0);

    // Contention from IDLE: owner 0 for exactly HOLD cycles, GAP, then owner 1
    req = 4'b0011;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (gnt !== 4'b0001) bad++;
    end
    check("cont_hold_bad_cycles", 64'(bad), 64'h0);
    @(negedge clk);
    check("cont_gap_gnt", 64'(gnt),   64'h0);
    check("cont_gap_hex", 64'(shown), 64'(BLANK_ALL));
    @(negedge clk);
    check("cont_next_gnt",   64'(gnt),   64'h2);
    check("cont_next_owner", 64'(owner), 64'h1);
    check("cont_next_hex",   64'(shown), 64'h15_14_13_12_11_10);

    // Move ownership to 3, then preempt with 1101: wrap must pick 0
    req = 4'b1000;
    @(negedge clk);
    check("to3_gap_gnt", 64'(gnt), 64'h0);
    @(negedge clk);
    check("to3_gnt",   64'(gnt),   64'h8);
    check("to3_owner", 64'(owner), 64'h3);
    req = 4'b1101;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (gnt !== 4'b1000) bad++;
    end
    check("wrap_hold_bad_cycles", 64'(bad), 64'h0);
    @(negedge clk);
    check("wrap_gap_gnt", 64'(gnt), 64'h0);
    @(negedge clk);
    check("wrap_gnt",   64'(gnt),   64'h1);
    check("wrap_owner", 64'(owner), 64'h0);
    check("wrap_busy",  64'(busy),  64'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
